// File: rtl/uart_tx_frm.sv
// rtl/uart_tx_frm.sv - UART transmit framer (start, LSB-first data, optional parity, stop); UART_TX_TWO_STOP_EN adds a second stop cycle
module uart_tx_frm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] data_reg, data_n;
    logic                  par_en_reg, par_en_n;
    logic                  par_typ_reg, par_typ_n;
    logic                  tx_n, busy_n;
    logic                  par_bit;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_cnt, stop_cnt_n;
`endif

    // Even type sends the XOR of the word; odd type sends its complement.
    assign par_bit = (^data_reg) ^ par_typ_reg;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            TX_OUT      <= 1'b1;
            BUSY        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            data_reg    <= data_n;
            par_en_reg  <= par_en_n;
            par_typ_reg <= par_typ_n;
            TX_OUT      <= tx_n;
            BUSY        <= busy_n;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt    <= stop_cnt_n;
`endif
        end
    end

    // Outputs are computed for the state being entered so the flops carry the line value directly.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        data_n    = data_reg;
        par_en_n  = par_en_reg;
        par_typ_n = par_typ_reg;
        tx_n      = 1'b1;
        busy_n    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_n = stop_cnt;
`endif
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (DATA_VALID) begin
                    state_n   = START;
                    data_n    = P_DATA;
                    par_en_n  = PAR_EN;
                    par_typ_n = PAR_TYP;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                state_n = DATA;
                cnt_n   = '0;
                tx_n    = data_reg[0];
            end
            DATA: begin
                if (cnt == CW'(DATA_WIDTH - 1)) begin
                    cnt_n = '0;
                    if (par_en_reg) begin
                        state_n = PARITY;
                        tx_n    = par_bit;
                    end else begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                    tx_n  = data_reg[cnt_n];
                end
            end
            PARITY: begin
                state_n = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                if (!stop_cnt) begin
                    stop_cnt_n = 1'b1;
                end else begin
                    stop_cnt_n = 1'b0;
                    state_n    = IDLE;
                    busy_n     = 1'b0;
                end
`else
                state_n = IDLE;
                busy_n  = 1'b0;
`endif
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frm.sv
// tb/tb_uart_tx_frm.sv - scoreboard bench for uart_tx_frm line and busy behaviour
module tb_uart_tx_frm;

    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         par_en;
    logic         par_typ;
    logic         tx_out;
    logic         busy;

    int           n_checks = 0;
    int           n_pass = 0;
    int           busy_cnt = 0;
    logic [1:0]   sb[$];

    uart_tx_frm #(.DATA_WIDTH(W)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .TX_OUT     (tx_out),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // {tx, busy}; an empty scoreboard means the line must be idle.
    task automatic cycle(input string tag);
        logic [1:0] exp;
        @(posedge clk);
        #1;
        exp = (sb.size() > 0) ? sb.pop_front() : 2'b10;
        if (busy === 1'b1) busy_cnt++;
        check(tag, {30'd0, tx_out, busy}, {30'd0, exp});
    endtask

    task automatic push_frame(input logic [W-1:0] d, input logic pen, input logic ptyp);
        int ones;
        ones = 0;
        sb.push_back(2'b01);
        for (int i = 0; i < W; i++) begin
            sb.push_back({d[i], 1'b1});
            if (d[i]) ones++;
        end
        if (pen) sb.push_back({((ones % 2) == 1) ^ ptyp, 1'b1});
        for (int i = 0; i < NSTOP; i++) sb.push_back(2'b11);
    endtask

    task automatic push_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) sb.push_back({bits[i], 1'b1});
    endtask

    task automatic accept(input logic [W-1:0] d, input logic pen, input logic ptyp, input string tag);
        p_data = d; par_en = pen; par_typ = ptyp; data_valid = 1'b1;
        busy_cnt = 0;
        cycle(tag);
        data_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) cycle(tag);
        cycle({tag, "_idle"});
    endtask

    initial begin
        rst = 1'b0; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
        cycle("reset0");
        data_valid = 1'b1; p_data = 8'hFF;
        cycle("reset_dv");
        data_valid = 1'b0;
        rst = 1'b1;
        cycle("idle0");
        cycle("idle1");

        // Even parity A5 against the literal line pattern.
        push_bits(16'b0101_0010_101, 11);
        for (int i = 1; i < NSTOP; i++) sb.push_back(2'b11);
        accept(8'hA5, 1'b1, 1'b0, "a5_even");
        drain("a5_even");
        check("a5_len", busy_cnt, 11 + NSTOP - 1);

        push_frame(8'h01, 1'b1, 1'b1);
        accept(8'h01, 1'b1, 1'b1, "x01_odd");
        drain("x01_odd");
        push_frame(8'h01, 1'b1, 1'b0);
        accept(8'h01, 1'b1, 1'b0, "x01_even");
        drain("x01_even");

        push_bits(16'b0111_1111_11, 10);
        for (int i = 1; i < NSTOP; i++) sb.push_back(2'b11);
        accept(8'hFF, 1'b0, 1'b0, "ff_nopar");
        drain("ff_nopar");
        check("ff_len", busy_cnt, 10 + NSTOP - 1);

        // Inputs disturbed mid-frame must not alter the latched word or start a new frame.
        push_frame(8'h3C, 1'b1, 1'b0);
        accept(8'h3C, 1'b1, 1'b0, "x3c");
        for (int i = 0; i < 3; i++) cycle("x3c");
        p_data = 8'h00; par_en = 1'b0; par_typ = 1'b1; data_valid = 1'b1;
        cycle("x3c_dv");
        data_valid = 1'b0;
        drain("x3c");
        cycle("x3c_idle2");

        // DATA_VALID held: exactly one idle high cycle between frames.
        push_frame(8'h6B, 1'b1, 1'b1);
        sb.push_back(2'b10);
        push_frame(8'h6B, 1'b1, 1'b1);
        p_data = 8'h6B; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        while (sb.size() > 0) cycle("held");
        data_valid = 1'b0;
        cycle("held_idle0");
        cycle("held_idle1");

        // Reset during data bit 4 abandons the frame.
        push_frame(8'h96, 1'b1, 1'b0);
        accept(8'h96, 1'b1, 1'b0, "rst_mid");
        for (int i = 0; i < 5; i++) cycle("rst_mid");
        sb.delete();
        rst = 1'b0;
        cycle("rst_mid_abort");
        rst = 1'b1;
        cycle("rst_mid_idle");
        push_frame(8'h5A, 1'b1, 1'b0);
        accept(8'h5A, 1'b1, 1'b0, "x5a");
        drain("x5a");
        check("x5a_len", busy_cnt, 11 + NSTOP - 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
